// File: rtl/noc_pkg.sv
// Shared mesh-router types: packet layout, output-port indices and VC buffer states.
// Pure declarations; no timing and no flow control of its own.
package noc_pkg;

  localparam int PACKET_WIDTH = 64;
  localparam int VC_BIT       = 63;

  typedef struct packed {
    logic        vc;
    logic [2:0]  dir;
    logic [3:0]  hop;
    logic [7:0]  src;
    logic [47:0] payload;
  } packet_t;

  typedef enum logic [2:0] {
    CW  = 3'd0,
    CCW = 3'd1,
    NS  = 3'd2,
    SN  = 3'd3,
    PE  = 3'd4
  } port_e;

  typedef enum logic {
    VC_EMPTY = 1'b0,
    VC_FULL  = 1'b1
  } vc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin pick: first eligible index at or after ptr, plus the pointer to resume from.
// Purely combinational; a requester that is not eligible is simply skipped.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      next_ptr
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      // Explicit wrap so non-power-of-two NUM_REQ never indexes past the last requester.
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!found && eligible[idx[PW-1:0]]) begin
        found               = 1'b1;
        gnt[idx[PW-1:0]]    = 1'b1;
        next_ptr            = (idx[PW-1:0] == PW'(NUM_REQ-1)) ? '0 : idx[PW-1:0] + PW'(1);
      end
    end
  end

endmodule

// File: rtl/out_port_arbiter.sv
// Output-link arbiter: round-robin fill of the internal-phase VC buffer, drain of the external one; request-to-so >= 1 cycle.
// ro low holds the packet until that VC's next external phase; a full VC grants nothing. OUTARB_STATS_EN adds grant_cnt.
module out_port_arbiter #(
  parameter int PACKET_WIDTH = noc_pkg::PACKET_WIDTH,
  parameter int NUM_REQ      = 4,
  parameter int VC_BIT       = noc_pkg::VC_BIT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            polarity,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            so,
  input  logic                            ro,
  output logic [PACKET_WIDTH-1:0]         dout
`ifdef OUTARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]           grant_cnt
`endif
);

  import noc_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  vc_state_e               state_q [2];
  vc_state_e               state_d [2];
  logic [PACKET_WIDTH-1:0] vc_buf  [2];
  logic [PW-1:0]           ptr_q   [2];

  logic                    ext_vc;
  logic                    int_vc;
  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [PW-1:0]           next_ptr;
  logic [PACKET_WIDTH-1:0] gnt_data;
  logic                    gnt_any;

  assign ext_vc = polarity;
  assign int_vc = ~polarity;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] && (req_data[i*PACKET_WIDTH + VC_BIT] == int_vc) &&
                    (state_q[int_vc] == VC_EMPTY);
    end
  end

  // One arbiter serves both VCs: only the internal VC fills in any cycle.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .eligible (eligible),
    .ptr      (ptr_q[int_vc]),
    .gnt      (arb_gnt),
    .next_ptr (next_ptr)
  );

  assign gnt     = reset ? arb_gnt : '0;
  assign gnt_any = |gnt;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_data = gnt_data | req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

  assign so   = (state_q[ext_vc] == VC_FULL);
  assign dout = so ? vc_buf[ext_vc] : '0;

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      state_d[v] = state_q[v];
      if ((1'(v) == ext_vc) && so && ro) state_d[v] = VC_EMPTY;
      if ((1'(v) == int_vc) && gnt_any)  state_d[v] = VC_FULL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < 2; v++) begin
        state_q[v] <= VC_EMPTY;
        vc_buf[v]  <= '0;
        ptr_q[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < 2; v++) state_q[v] <= state_d[v];
      if (gnt_any) begin
        vc_buf[int_vc] <= gnt_data;
        ptr_q[int_vc]  <= next_ptr;
      end
    end
  end

`ifdef OUTARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: reset, single packet, round-robin, backpressure and mixed-VC traffic.
// Drained packets are matched in order against a queue of packets the bench expects to be granted.
module tb_out_port_arbiter;
  import noc_pkg::*;

  localparam int NR = 4;
  localparam int W  = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             polarity;
  logic             ro;
  logic             so;
  logic [NR-1:0]    req;
  logic [NR-1:0]    gnt;
  logic [NR*W-1:0]  req_data;
  logic [W-1:0]     dout;
`ifdef OUTARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] pkt   [NR];
  logic [W-1:0] mon_exp;
  logic [W-1:0] pa, ps, pb, pc, pd, pe;
  logic [NR-1:0] oh;

  always #5 clk = ~clk;

  out_port_arbiter #(
    .PACKET_WIDTH (W),
    .NUM_REQ      (NR),
    .VC_BIT       (63)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .so       (so),
    .ro       (ro),
    .dout     (dout)
`ifdef OUTARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic vc, input logic [7:0] src, input logic [7:0] tag);
    packet_t p;
    p         = '0;
    p.vc      = vc;
    p.src     = src;
    p.payload = {40'h0, tag};
    return p;
  endfunction

  task automatic drive(input int i, input logic on, input logic [W-1:0] d);
    req[i]             = on;
    req_data[i*W +: W] = d;
  endtask

  // Advance one router cycle; polarity flips just after the edge like the polarity register would.
  task automatic cyc();
    @(posedge clk);
    #1 polarity = ~polarity;
  endtask

  // Every accepted transfer on the link must be the next packet the bench expects.
  always @(negedge clk) begin
    if (reset === 1'b1 && so === 1'b1 && ro === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_so", 64'(so), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("drain_dout", dout, mon_exp);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    polarity = 1'b0;
    ro       = 1'b0;
    req      = '0;
    req_data = '0;

    // Reset: outputs quiet, grant suppressed even with an eligible request.
    #1;
    check("rst_so",   64'(so),  64'd0);
    check("rst_dout", dout,     64'd0);
    check("rst_gnt",  64'(gnt), 64'd0);
    pa = mk(1'b1, 8'd0, 8'h11);
    drive(0, 1'b1, pa);
    #1 check("rst_gnt_with_req", 64'(gnt), 64'd0);
    cyc(); reset = 1'b1;                                  // pol 1: VC1 packet is external-phase
    #1 check("wrong_vc_wait", 64'(gnt), 64'd0);
    cyc();                                                // pol 0
    #1 check("rst_fill_gnt", 64'(gnt), 64'(4'b0001));
    cyc(); drive(0, 1'b0, '0);                            // pol 1, ro=0 holds the packet
    #1 check("pre_rst_so", 64'(so), 64'd1);
    check("pre_rst_dout", dout, pa);
    reset = 1'b0;
    #1 check("mid_rst_so", 64'(so), 64'd0);
    check("mid_rst_dout", dout, 64'd0);
    check("mid_rst_gnt",  64'(gnt), 64'd0);
    cyc(); reset = 1'b1;                                  // pol 0
    cyc(); ro = 1'b1;                                     // pol 1
    #1 check("post_rst_so", 64'(so), 64'd0);

    // Single packet on VC1 from requester 2.
    cyc();                                                // pol 0
    ps = 64'h8000_0000_0000_00AA;
    drive(2, 1'b1, ps);
    #1 check("single_gnt", 64'(gnt), 64'(4'b0100));
    exp_q.push_back(ps);
    cyc(); drive(2, 1'b0, '0);                            // pol 1
    #1 check("single_so", 64'(so), 64'd1);
    check("single_dout", dout, ps);
    cyc();                                                // pol 0
    #1 check("single_so_after", 64'(so), 64'd0);

    // Round-robin: all four hold VC0 packets, expect 0,1,2,3,0 one every two cycles.
    for (int i = 0; i < NR; i++) begin
      pkt[i] = mk(1'b0, 8'(i), 8'(8'h20 + i));
      drive(i, 1'b1, pkt[i]);
    end
    #1 check("rr_wrong_phase", 64'(gnt), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();                                              // pol 1: VC0 fills
      oh = NR'(1) << (k % NR);
      #1 check("rr_gnt", 64'(gnt), 64'(oh));
      exp_q.push_back(pkt[k % NR]);
      cyc();                                              // pol 0: VC0 drains
      if (k < 4) begin
        pkt[k % NR] = mk(1'b0, 8'(k % NR), 8'(8'h40 + k));
        drive(k % NR, 1'b1, pkt[k % NR]);
      end else begin
        req = '0;
      end
      #1 check("rr_idle_gnt", 64'(gnt), 64'd0);
      check("rr_so", 64'(so), 64'd1);
    end

    // Backpressure on VC1: held for six cycles, then drains and regrants.
    cyc(); ro = 1'b0;                                     // pol 1
    pb = mk(1'b1, 8'd1, 8'hB0);
    drive(1, 1'b1, pb);
    #1 check("bp_wrong_phase", 64'(gnt), 64'd0);
    cyc();                                                // pol 0
    #1 check("bp_first_gnt", 64'(gnt), 64'(4'b0010));
    exp_q.push_back(pb);
    cyc();                                                // pol 1
    pc = mk(1'b1, 8'd1, 8'hC0);
    drive(1, 1'b1, pc);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) cyc();
      #1;
      if (polarity) begin
        check("bp_so_held", 64'(so), 64'd1);
        check("bp_dout_stable", dout, pb);
      end else begin
        check("bp_so_off", 64'(so), 64'd0);
        check("bp_full_gnt", 64'(gnt), 64'd0);
      end
    end
    cyc(); ro = 1'b1;                                     // pol 1
    #1 check("bp_release_so", 64'(so), 64'd1);
    check("bp_release_dout", dout, pb);
    cyc();                                                // pol 0
    #1 check("bp_regrant", 64'(gnt), 64'(4'b0010));
    exp_q.push_back(pc);
    cyc(); drive(1, 1'b0, '0);                            // pol 1
    #1 check("bp_second_so", 64'(so), 64'd1);
    check("bp_second_dout", dout, pc);

    // Mixed VCs: each requester is granted only in its own internal phase.
    cyc();                                                // pol 0
    cyc();                                                // pol 1
    pd = mk(1'b0, 8'd0, 8'hD0);
    pe = mk(1'b1, 8'd1, 8'hE0);
    drive(0, 1'b1, pd);
    drive(1, 1'b1, pe);
    #1 check("mix_gnt_vc0", 64'(gnt), 64'(4'b0001));
    exp_q.push_back(pd);
    cyc(); drive(0, 1'b0, '0);                            // pol 0
    #1 check("mix_gnt_vc1", 64'(gnt), 64'(4'b0010));
    exp_q.push_back(pe);
    check("mix_so_vc0", 64'(so), 64'd1);
    check("mix_dout_vc0", dout, pd);
    cyc(); drive(1, 1'b0, '0);                            // pol 1
    #1 check("mix_so_vc1", 64'(so), 64'd1);
    check("mix_dout_vc1", dout, pe);
    cyc();                                                // pol 0
    #1 check("mix_idle_so0", 64'(so), 64'd0);
    cyc();                                                // pol 1
    #1 check("mix_idle_so1", 64'(so), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
